// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and widths for the memory port arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I-side, D-side and downstream memory signals of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);

  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_wdata;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic [1:0]        busy;

  // Arbiter's view of the bus
  modport slave (
    input  i_read, i_write, i_address, i_wdata,
    input  d_read, d_write, d_address, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output busy
  );

  // Caches and downstream memory as seen from outside the arbiter
  modport master (
    output i_read, i_write, i_address, i_wdata,
    output d_read, d_write, d_address, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - round-robin next-owner selection
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_side_t last_grant,
  output logic      grant_valid,
  output arb_side_t grant_side
);

  // On contention the side that did not win last time goes first
  always_comb begin
    grant_valid = i_req | d_req;
    grant_side  = SIDE_I;
    if (i_req && d_req) begin
      grant_side = (last_grant == SIDE_D) ? SIDE_I : SIDE_D;
    end else if (d_req) begin
      grant_side = SIDE_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I-side and D-side line requesters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state;
  arb_side_t         last_grant;
  logic              i_req;
  logic              d_req;
  logic              pick_valid;
  arb_side_t         pick_side;

  logic              own_act;
  logic              own_sel;
  logic              own_read;
  logic              own_write;
  logic [ADDR_W-1:0] own_address;
  logic [LINE_W-1:0] own_wdata;

  assign i_req = bus.i_read | bus.i_write;
  assign d_req = bus.d_read | bus.d_write;

  mem_arbiter_rr_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant_side  (pick_side)
  );

  // Ownership FSM; last_grant only moves when both sides competed
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SIDE_D;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= (pick_side == SIDE_I) ? BUSY_I : BUSY_D;
            if (i_req && d_req) begin
              last_grant <= pick_side;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.pmem_resp) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Owner mux: downstream port follows the owning requester, quiet otherwise
  always_comb begin
    own_act     = (state == BUSY_I) || (state == BUSY_D);
    own_sel     = (state == BUSY_D);
    own_read    = own_sel ? bus.d_read    : bus.i_read;
    own_write   = own_sel ? bus.d_write   : bus.i_write;
    own_address = own_sel ? bus.d_address : bus.i_address;
    own_wdata   = own_sel ? bus.d_wdata   : bus.i_wdata;

    // read+write together is treated as a write
    bus.pmem_write   = own_act & own_write;
    bus.pmem_read    = own_act & own_read & ~own_write;
    bus.pmem_address = own_act ? own_address : '0;
    bus.pmem_wdata   = own_act ? own_wdata   : '0;

    bus.i_rdata = bus.pmem_rdata;
    bus.d_rdata = bus.pmem_rdata;
    bus.i_resp  = (state == BUSY_I) & bus.pmem_resp;
    bus.d_resp  = (state == BUSY_D) & bus.pmem_resp;
    bus.busy    = {own_sel, own_act};
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed checks of the memory port arbiter
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

  mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         side;     // 0 = I, 1 = D
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           lat;
    logic         exp_read;
    logic         exp_write;
    logic [1:0]   exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic side, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [127:0] wdata);
    if (side) begin
      bus.d_read = rd; bus.d_write = wr; bus.d_address = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_read = rd; bus.i_write = wr; bus.i_address = addr; bus.i_wdata = wdata;
    end
  endtask

  task automatic clear_req(input logic side);
    set_req(side, 1'b0, 1'b0, 16'h0, 128'h0);
  endtask

  // Called in a BUSY cycle: return pmem_resp, check the pulse, walk through DONE into IDLE
  task automatic finish_owner(input string name, input logic side, input logic keep);
    bus.pmem_resp = 1'b1;
    #1;
    check({name, "_own_resp"}, side ? bus.d_resp : bus.i_resp, 1'b1);
    check({name, "_other_resp"}, side ? bus.i_resp : bus.d_resp, 1'b0);
    tick;
    bus.pmem_resp = 1'b0;
    if (!keep) clear_req(side);
    #1;
    check({name, "_done_quiet"}, {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.busy}, 6'b0);
    tick;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    clear_req(1'b0);
    clear_req(1'b1);
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0040, 128'h0, {16{8'hA5}}, 3, 1'b1, 1'b0, 2'b01};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h1230, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF, 128'h0, 2, 1'b0, 1'b1, 2'b11};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h2000, 128'h0, {16{8'h5A}}, 1, 1'b1, 1'b0, 2'b11};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0080, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0, 4, 1'b0, 1'b1, 2'b01};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h00C0, 128'hCAFE, 128'h0, 0, 1'b0, 1'b1, 2'b01};

    // Reset state
    tick;
    tick;
    check("reset_outputs", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.busy}, 6'b0);
    check("reset_addr", bus.pmem_address, 16'h0);
    rst = 1'b0;
    tick;

    // Single-requester transactions from the table
    for (int k = 0; k < 5; k++) begin
      if (vecs[k].rd && vecs[k].wr) $display("note: vector %0d drives read and write together (illegal stimulus)", k);
      set_req(vecs[k].side, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      #1;
      check($sformatf("v%0d_idle_no_strobe", k), {bus.pmem_read, bus.pmem_write}, 2'b00);
      tick;
      check($sformatf("v%0d_read", k), bus.pmem_read, vecs[k].exp_read);
      check($sformatf("v%0d_write", k), bus.pmem_write, vecs[k].exp_write);
      check($sformatf("v%0d_addr", k), bus.pmem_address, vecs[k].addr);
      check($sformatf("v%0d_wdata", k), bus.pmem_wdata, vecs[k].wdata);
      check($sformatf("v%0d_busy", k), bus.busy, vecs[k].exp_busy);
      for (int c = 0; c < vecs[k].lat; c++) tick;
      bus.pmem_rdata = vecs[k].rdata;
      check($sformatf("v%0d_strobe_held", k), {bus.pmem_read, bus.pmem_write}, {vecs[k].exp_read, vecs[k].exp_write});
      bus.pmem_resp = 1'b1;
      #1;
      check($sformatf("v%0d_own_resp", k), vecs[k].side ? bus.d_resp : bus.i_resp, 1'b1);
      check($sformatf("v%0d_other_resp", k), vecs[k].side ? bus.i_resp : bus.d_resp, 1'b0);
      check($sformatf("v%0d_rdata", k), vecs[k].side ? bus.d_rdata : bus.i_rdata, vecs[k].rdata);
      tick;
      bus.pmem_resp = 1'b0;
      clear_req(vecs[k].side);
      #1;
      check($sformatf("v%0d_done_quiet", k), {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.busy}, 6'b0);
      tick;
      check($sformatf("v%0d_idle_busy", k), bus.busy, 2'b00);
    end

    // Simultaneous requests right after reset: I wins, D follows at n+2/n+3
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 16'h0100, 128'h0);
    set_req(1'b1, 1'b1, 1'b0, 16'h2000, 128'h0);
    tick;
    check("sim1_busy_i", bus.busy, 2'b01);
    check("sim1_addr_i", bus.pmem_address, 16'h0100);
    finish_owner("sim1_i", 1'b0, 1'b0);
    check("sim1_idle_no_strobe", {bus.pmem_read, bus.busy}, 3'b000);
    tick;
    check("sim1_busy_d", bus.busy, 2'b11);
    check("sim1_addr_d", bus.pmem_address, 16'h2000);
    finish_owner("sim1_d", 1'b1, 1'b0);

    // Second simultaneous pair: D goes first
    set_req(1'b0, 1'b1, 1'b0, 16'h0140, 128'h0);
    set_req(1'b1, 1'b1, 1'b0, 16'h2040, 128'h0);
    tick;
    check("sim2_busy_d", bus.busy, 2'b11);
    finish_owner("sim2_d", 1'b1, 1'b0);
    tick;
    check("sim2_busy_i", bus.busy, 2'b01);
    finish_owner("sim2_i", 1'b0, 1'b0);

    // Both sides held over four fills: strict alternation, no re-grant out of DONE
    set_req(1'b0, 1'b1, 1'b0, 16'h0200, 128'h0);
    set_req(1'b1, 1'b1, 1'b0, 16'h3000, 128'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d_idle_no_strobe", k), {bus.pmem_read, bus.pmem_write}, 2'b00);
      tick;
      check($sformatf("rr%0d_busy", k), bus.busy, (k % 2 == 0) ? 2'b01 : 2'b11);
      finish_owner($sformatf("rr%0d", k), (k % 2 == 0) ? 1'b0 : 1'b1, 1'b1);
    end
    clear_req(1'b0);
    clear_req(1'b1);
    tick;

    // Reset in BUSY_D two cycles after the strobe; late pmem_resp is dropped
    set_req(1'b1, 1'b1, 1'b0, 16'h4000, 128'h0);
    tick;
    check("rst_busy_d", bus.busy, 2'b11);
    tick;
    tick;
    rst = 1'b1;
    clear_req(1'b1);
    tick;
    rst = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    check("rst_after_quiet", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, bus.busy}, 6'b0);
    tick;
    bus.pmem_resp = 1'b0;
    check("rst_stays_idle", bus.busy, 2'b00);

    // Spurious pmem_resp in IDLE produces no pulse
    bus.pmem_resp = 1'b1;
    #1;
    check("spurious_resp", {bus.i_resp, bus.d_resp, bus.busy}, 4'b0);
    tick;
    bus.pmem_resp = 1'b0;
    tick;
    check("spurious_idle", bus.busy, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
